// File: rtl/feature_weight_accum.sv
`default_nettype none
// feature_weight_accum: signed weighted accumulation of rectangle sums into Haar feature values.
// Define FEATURE_SAT_EN to saturate accumulator updates; otherwise they wrap two's complement.
module feature_weight_accum #(
  parameter int W_DATA     = 3,
  parameter int W_ADDR     = 12,
  parameter int NUM_RECTS  = 52,
  parameter int W_RECT_SUM = 18,
  parameter int W_FEAT_SUM = 24,
  parameter int W_FEAT_IDX = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         restart,
  input  logic                         rect_valid,
  output logic                         rect_ready,
  input  logic [W_RECT_SUM-1:0]        rect_sum,
  input  logic                         rect_last,
  output logic                         weight_en,
  output logic [W_ADDR-1:0]            weight_addr,
  input  logic [W_DATA-1:0]            weight_data,
  output logic                         feat_valid,
  input  logic                         feat_ready,
  output logic signed [W_FEAT_SUM-1:0] feat_sum,
  output logic [W_FEAT_IDX-1:0]        feat_idx
);

  localparam int W_TERM = W_DATA + W_RECT_SUM;
  localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(NUM_RECTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W_ADDR-1:0]            rect_addr;
  logic [W_ADDR-1:0]            addr_hold;
  logic [W_RECT_SUM-1:0]        sum_q;
  logic                         last_q;
  logic                         first;
  logic signed [W_FEAT_SUM-1:0] acc;
  logic signed [W_FEAT_SUM-1:0] acc_nxt;
  logic [W_TERM-1:0]            term;
  logic                         accept;
  logic                         feat_take;

  // Ready is held low while reset is asserted, even though the state is already IDLE.
  assign rect_ready  = rst && (state == IDLE);
  assign accept      = rect_valid && rect_ready && !restart;
  assign weight_en   = accept;
  assign weight_addr = accept ? rect_addr : addr_hold;
  assign feat_valid  = (state == OUT);
  assign feat_take   = feat_valid && feat_ready;

  assign term = W_TERM'(weight_data) * W_TERM'(sum_q);

`ifdef FEATURE_SAT_EN
  // Wide enough that neither the product nor the running sum can wrap before clamping.
  localparam int W_EXT = ((W_TERM > W_FEAT_SUM) ? W_TERM : W_FEAT_SUM) + 2;
  localparam logic signed [W_EXT-1:0] MAX_EXT =
    $signed({{(W_EXT-W_FEAT_SUM+1){1'b0}}, {(W_FEAT_SUM-1){1'b1}}});
  localparam logic signed [W_EXT-1:0] MIN_EXT = ~MAX_EXT;

  logic signed [W_EXT-1:0] term_ext;
  logic signed [W_EXT-1:0] acc_ext;
  logic signed [W_EXT-1:0] upd;

  assign term_ext = $signed({{(W_EXT-W_TERM){1'b0}}, term});
  assign acc_ext  = $signed({{(W_EXT-W_FEAT_SUM){acc[W_FEAT_SUM-1]}}, acc});
  assign upd      = first ? -term_ext : acc_ext + term_ext;

  always_comb begin
    acc_nxt = upd[W_FEAT_SUM-1:0];
    if (upd > MAX_EXT) begin
      acc_nxt = MAX_EXT[W_FEAT_SUM-1:0];
    end else if (upd < MIN_EXT) begin
      acc_nxt = MIN_EXT[W_FEAT_SUM-1:0];
    end
  end
`else
  logic signed [W_FEAT_SUM-1:0] term_f;

  assign term_f  = $signed(W_FEAT_SUM'(term));
  assign acc_nxt = first ? -term_f : acc + term_f;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     state_nxt = last_q ? OUT : IDLE;
      OUT:     if (feat_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (restart) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rect_addr <= '0;
      addr_hold <= '0;
      feat_idx  <= '0;
      acc       <= '0;
      first     <= 1'b1;
      sum_q     <= '0;
      last_q    <= 1'b0;
      feat_sum  <= '0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        rect_addr <= '0;
        feat_idx  <= '0;
        acc       <= '0;
        first     <= 1'b1;
      end else begin
        if (accept) begin
          sum_q     <= rect_sum;
          last_q    <= rect_last;
          addr_hold <= rect_addr;
        end
        if (state == MAC) begin
          acc       <= acc_nxt;
          first     <= 1'b0;
          rect_addr <= (rect_addr == LAST_ADDR) ? '0 : rect_addr + W_ADDR'(1);
          if (last_q) feat_sum <= acc_nxt;
        end
        if (feat_take) begin
          feat_idx <= feat_idx + W_FEAT_IDX'(1);
          first    <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_feature_weight_accum.sv
`default_nettype none
// tb_feature_weight_accum: randomized stimulus against a transaction-level reference model.
module tb_feature_weight_accum;

  localparam int W_DATA     = 3;
  localparam int W_ADDR     = 12;
  localparam int NUM_RECTS  = 52;
  localparam int W_RECT_SUM = 18;
  localparam int W_FEAT_SUM = 24;
  localparam int W_FEAT_IDX = 10;
  localparam longint MAXV   = (longint'(1) << (W_FEAT_SUM - 1)) - 1;
  localparam longint MINV   = -MAXV - 1;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic                         restart = 1'b0;
  logic                         rect_valid = 1'b0;
  logic                         rect_ready;
  logic [W_RECT_SUM-1:0]        rect_sum = '0;
  logic                         rect_last = 1'b0;
  logic                         weight_en;
  logic [W_ADDR-1:0]            weight_addr;
  logic [W_DATA-1:0]            weight_data = '0;
  logic                         feat_valid;
  logic                         feat_ready = 1'b0;
  logic signed [W_FEAT_SUM-1:0] feat_sum;
  logic [W_FEAT_IDX-1:0]        feat_idx;

  always #5 clk = ~clk;

  feature_weight_accum #(
    .W_DATA(W_DATA), .W_ADDR(W_ADDR), .NUM_RECTS(NUM_RECTS),
    .W_RECT_SUM(W_RECT_SUM), .W_FEAT_SUM(W_FEAT_SUM), .W_FEAT_IDX(W_FEAT_IDX)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .rect_valid(rect_valid), .rect_ready(rect_ready), .rect_sum(rect_sum), .rect_last(rect_last),
    .weight_en(weight_en), .weight_addr(weight_addr), .weight_data(weight_data),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_sum(feat_sum), .feat_idx(feat_idx)
  );

  function automatic int rom_w(input int a);
    if (a < 4) return 3;
    if (a == 4) return 2;
    return (a * 5 + 1) % 8;
  endfunction

  // Weight ROM with one cycle of read latency.
  always @(posedge clk) if (weight_en) weight_data <= W_DATA'(rom_w(int'(weight_addr)));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fit(input longint v);
`ifdef FEATURE_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
`else
    longint m;
    m = v & ((longint'(1) << W_FEAT_SUM) - 1);
    if (m > MAXV) m -= (longint'(1) << W_FEAT_SUM);
    return m;
`endif
  endfunction

  // Reference model state: one expected result at a time, addresses and indices as counters.
  longint m_acc = 0;
  longint m_out = 0;
  bit     m_first = 1'b1;
  int     m_addr = 0;
  int     m_hold = 0;
  int     m_idx = 0;
  bit     out_pend = 1'b0;
  int     cyc = 0;
  int     acc_cyc = -10;
  int     force_rdy = 1;
  bit     valid_always = 1'b1;
  int     pend_sum[$];
  bit     pend_last[$];

  task automatic push_feature(input int len, input bit max_sums);
    for (int i = 0; i < len; i++) begin
      pend_sum.push_back(max_sums ? (1 << W_RECT_SUM) - 1 : int'($urandom_range(0, (1 << W_RECT_SUM) - 1)));
      pend_last.push_back(i == len - 1);
    end
  endtask

  task automatic push_rect(input int s, input bit l);
    pend_sum.push_back(s);
    pend_last.push_back(l);
  endtask

  task automatic model_clear(input bit clear_hold);
    m_addr   = 0;
    m_idx    = 0;
    m_first  = 1'b1;
    m_acc    = 0;
    out_pend = 1'b0;
    acc_cyc  = -10;
    if (clear_hold) m_hold = 0;
    pend_sum.delete();
    pend_last.delete();
  endtask

  task automatic cycle();
    bit     exp_rdy;
    bit     exp_fv;
    longint w;
    @(negedge clk);
    cyc++;
    restart = 1'b0;
    feat_ready = (force_rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(force_rdy);
    if (pend_sum.size() > 0 && (valid_always || $urandom_range(0, 3) != 0)) begin
      rect_valid = 1'b1;
      rect_sum   = W_RECT_SUM'(pend_sum[0]);
      rect_last  = pend_last[0];
    end else begin
      rect_valid = 1'b0;
      rect_sum   = W_RECT_SUM'($urandom);
      rect_last  = 1'($urandom);
    end
    #1;
    exp_rdy = !out_pend && (cyc != acc_cyc + 1);
    exp_fv  = out_pend && (cyc >= acc_cyc + 2);
    check("rect_ready", rect_ready, exp_rdy);
    check("weight_en", weight_en, rect_valid && exp_rdy);
    check("feat_valid", feat_valid, exp_fv);
    if (exp_fv) begin
      check("feat_sum", feat_sum, m_out);
      check("feat_idx", feat_idx, m_idx);
      if (feat_ready) begin
        out_pend = 1'b0;
        m_first  = 1'b1;
        m_idx    = (m_idx + 1) % (1 << W_FEAT_IDX);
      end
    end
    if (rect_valid && exp_rdy) begin
      check("weight_addr", weight_addr, m_addr);
      w = rom_w(m_addr);
      m_acc   = m_first ? fit(-w * pend_sum[0]) : fit(m_acc + w * pend_sum[0]);
      m_first = 1'b0;
      m_hold  = m_addr;
      m_addr  = (m_addr + 1) % NUM_RECTS;
      acc_cyc = cyc;
      if (pend_last[0]) begin
        out_pend = 1'b1;
        m_out    = m_acc;
      end
      void'(pend_sum.pop_front());
      void'(pend_last.pop_front());
    end else begin
      check("addr_hold", weight_addr, m_hold);
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((pend_sum.size() > 0 || out_pend) && n < limit) begin
      cycle();
      n++;
    end
    check("drain_timeout", pend_sum.size() + int'(out_pend), 0);
    cycle();
  endtask

  task automatic do_restart();
    @(negedge clk);
    cyc++;
    restart    = 1'b1;
    rect_valid = 1'b1;
    rect_sum   = W_RECT_SUM'($urandom);
    rect_last  = 1'b1;
    feat_ready = 1'b1;
    #1;
    check("weight_en_restart", weight_en, 1'b0);
    model_clear(1'b0);
  endtask

  task automatic reset_mid_mac();
    int guard = 0;
    valid_always = 1'b1;
    push_feature(3, 1'b0);
    while (acc_cyc != cyc && guard < 50) begin
      cycle();
      guard++;
    end
    check("reach_mac", acc_cyc, cyc);
    @(negedge clk);
    cyc++;
    rst        = 1'b0;
    rect_valid = 1'b1;
    #1;
    check("rst_feat_valid", feat_valid, 1'b0);
    check("rst_weight_en", weight_en, 1'b0);
    check("rst_rect_ready", rect_ready, 1'b0);
    check("rst_weight_addr", weight_addr, 0);
    repeat (2) @(negedge clk);
    cyc += 2;
    rect_valid = 1'b0;
    rst        = 1'b1;
    model_clear(1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_feat_valid", feat_valid, 1'b0);
    check("reset_weight_en", weight_en, 1'b0);
    check("reset_weight_addr", weight_addr, 0);
    check("reset_feat_sum", feat_sum, 0);
    check("reset_feat_idx", feat_idx, 0);
    check("reset_rect_ready", rect_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Directed two- and three-rectangle features with back-to-back valid.
    force_rdy = 1;
    valid_always = 1'b1;
    push_rect(100, 1'b0); push_rect(40, 1'b1);
    push_rect(10, 1'b0);  push_rect(20, 1'b0); push_rect(30, 1'b1);
    drain(100);

    // Result held under backpressure, then released.
    force_rdy = 0;
    push_rect(100, 1'b0); push_rect(40, 1'b1);
    for (int i = 0; i < 40 && !(out_pend && cyc >= acc_cyc + 2); i++) cycle();
    repeat (5) cycle();
    force_rdy = 1;
    drain(50);

    reset_mid_mac();
    push_feature(2, 1'b0);
    drain(100);

    // Single-rectangle features walk the address through its wrap point.
    force_rdy = -1;
    valid_always = 1'b0;
    for (int i = 0; i < 60; i++) push_feature(1, 1'b0);
    drain(2000);

    // Restart while a feature is only partly accumulated.
    push_feature(6, 1'b0);
    repeat (5) cycle();
    do_restart();
    push_feature(3, 1'b0);
    drain(200);

    // Large sums drive the accumulator past the signed range.
    push_feature(14, 1'b1);
    push_feature(14, 1'b1);
    drain(500);

    for (int i = 0; i < 40; i++) push_feature(int'($urandom_range(1, 5)), 1'b0);
    drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
